// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Single-clock parametrised FIFO with occupancy count, programmable
//            almost-full/almost-empty flags and overflow/underflow pulses.
//            Define FIFO_FWFT_EN for first-word-fall-through output.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int AF_LEVEL   = FIFO_DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FIFO_WIDTH-1:0]         din,
    input  logic                          wen,
    input  logic                          ren,
    output logic [FIFO_WIDTH-1:0]         dout,
    output logic                          valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int              c_AW    = $clog2(FIFO_DEPTH);
    localparam int              c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_AF    = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_AE    = c_CW'(AE_LEVEL);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_CW-1:0]       w_count_nxt;

    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign w_rd_acc = ren && !r_empty;
    assign w_wr_acc = wen && (!r_full || w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_CW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= c_AF);
            r_ae    <= (w_count_nxt <= c_AE);
            r_ovf   <= wen && !w_wr_acc;
            r_unf   <= ren && r_empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; masked to zero while empty so reset shows 0.
    assign dout  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign valid = !r_empty;
`else
    logic [FIFO_WIDTH-1:0] r_dout;
    logic                  r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout <= r_mem[r_rd_ptr];
            end
        end
    end

    assign dout  = r_dout;
    assign valid = r_valid;
`endif

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param (depth 16 and
//            depth 8 instances); honours FIFO_FWFT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        wen;
    logic        ren;
    logic        sel;

    logic [15:0] dout_a, dout_b;
    logic        valid_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic        valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [4:0]  count_a;
    logic [3:0]  count_b;

    logic [31:0] m_dout;
    logic [31:0] m_count;
    logic        m_valid, m_full, m_empty, m_af, m_ae, m_ovf, m_unf;

    int n_chk  = 0;
    int n_fail = 0;

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) dut_a (
        .clk(clk), .rst(rst), .din(din), .wen(wen), .ren(ren),
        .dout(dout_a), .valid(valid_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(4), .AE_LEVEL(2)) dut_b (
        .clk(clk), .rst(rst), .din(din), .wen(wen), .ren(ren),
        .dout(dout_b), .valid(valid_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        m_dout  = sel ? {16'h0, dout_b} : {16'h0, dout_a};
        m_count = sel ? {28'h0, count_b} : {27'h0, count_a};
        m_valid = sel ? valid_b : valid_a;
        m_full  = sel ? full_b  : full_a;
        m_empty = sel ? empty_b : empty_a;
        m_af    = sel ? af_b    : af_a;
        m_ae    = sel ? ae_b    : ae_a;
        m_ovf   = sel ? ovf_b   : ovf_a;
        m_unf   = sel ? unf_b   : unf_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        din = d;
        wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd_expect(input logic [15:0] exp);
`ifdef FIFO_FWFT_EN
        check("fwft_dout", m_dout, {16'h0, exp});
        check("fwft_valid", {31'h0, m_valid}, 32'd1);
        ren = 1'b1;
        tick();
        ren = 1'b0;
`else
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("rd_dout", m_dout, {16'h0, exp});
        check("rd_valid", {31'h0, m_valid}, 32'd1);
`endif
    endtask

    initial begin
        rst = 1'b0;
        din = '0;
        wen = 1'b0;
        ren = 1'b0;
        sel = 1'b0;
        repeat (2) tick();

        // Reset state on the depth-16 instance
        check("rst_count", m_count, 32'd0);
        check("rst_empty", {31'h0, m_empty}, 32'd1);
        check("rst_ae", {31'h0, m_ae}, 32'd1);
        check("rst_full", {31'h0, m_full}, 32'd0);
        check("rst_af", {31'h0, m_af}, 32'd0);
        check("rst_valid", {31'h0, m_valid}, 32'd0);
        check("rst_dout", m_dout, 32'd0);
        check("rst_ovf", {31'h0, m_ovf}, 32'd0);
        check("rst_unf", {31'h0, m_unf}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 1; i <= 10; i++) wr(16'(i));
        check("a_cnt10", m_count, 32'd10);
        check("a_empty10", {31'h0, m_empty}, 32'd0);
        check("a_ae10", {31'h0, m_ae}, 32'd0);
        check("a_af10", {31'h0, m_af}, 32'd0);
        check("a_ovf10", {31'h0, m_ovf}, 32'd0);
        for (int i = 1; i <= 10; i++) rd_expect(16'(i));
        check("a_cnt0", m_count, 32'd0);
        check("a_empty0", {31'h0, m_empty}, 32'd1);
        tick();
        check("a_valid_idle", {31'h0, m_valid}, 32'd0);
`ifndef FIFO_FWFT_EN
        check("a_dout_hold", m_dout, 32'h000A);
`endif
        check("a_unf_idle", {31'h0, m_unf}, 32'd0);

        // Depth-8 instance: fill, overflow, drain
        sel = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            wr(16'h0010 + 16'(i));
            check("b_fill_cnt", m_count, 32'(i + 1));
            check("b_fill_af", {31'h0, m_af}, (i + 1 >= 4) ? 32'd1 : 32'd0);
            check("b_fill_full", {31'h0, m_full}, (i == 7) ? 32'd1 : 32'd0);
            check("b_fill_ae", {31'h0, m_ae}, (i + 1 <= 2) ? 32'd1 : 32'd0);
        end
        wr(16'h00EE);
        check("b_ovf", {31'h0, m_ovf}, 32'd1);
        check("b_ovf_cnt", m_count, 32'd8);
        check("b_ovf_full", {31'h0, m_full}, 32'd1);
        tick();
        check("b_ovf_pulse", {31'h0, m_ovf}, 32'd0);
        for (int i = 0; i < 8; i++) rd_expect(16'h0010 + 16'(i));
        check("b_drain_empty", {31'h0, m_empty}, 32'd1);
        check("b_drain_cnt", m_count, 32'd0);
        tick();

        // Underflow on empty, then simultaneous write+read on empty
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("b_unf", {31'h0, m_unf}, 32'd1);
        check("b_unf_cnt", m_count, 32'd0);
        check("b_unf_valid", {31'h0, m_valid}, 32'd0);
`ifdef FIFO_FWFT_EN
        check("b_unf_dout", m_dout, 32'd0);
`else
        check("b_unf_dout", m_dout, 32'h0017);
`endif
        din = 16'h0055;
        wen = 1'b1;
        ren = 1'b1;
        tick();
        wen = 1'b0;
        ren = 1'b0;
        check("b_wr_rd_empty_cnt", m_count, 32'd1);
        check("b_wr_rd_empty_unf", {31'h0, m_unf}, 32'd1);
        check("b_wr_rd_empty_empty", {31'h0, m_empty}, 32'd0);
        tick();
        check("b_unf_pulse", {31'h0, m_unf}, 32'd0);
        rd_expect(16'h0055);

        // Full with wen+ren for 3 cycles, across pointer wrap
        for (int i = 0; i < 8; i++) wr(16'h0020 + 16'(i));
        check("b_full2", {31'h0, m_full}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            din = 16'h0030 + 16'(k);
            wen = 1'b1;
            ren = 1'b1;
`ifdef FIFO_FWFT_EN
            check("b_wr_rd_full_dout", m_dout, 32'h0020 + 32'(k));
            tick();
`else
            tick();
            check("b_wr_rd_full_dout", m_dout, 32'h0020 + 32'(k));
            check("b_wr_rd_full_valid", {31'h0, m_valid}, 32'd1);
`endif
            check("b_wr_rd_full_cnt", m_count, 32'd8);
            check("b_wr_rd_full_full", {31'h0, m_full}, 32'd1);
            check("b_wr_rd_full_ovf", {31'h0, m_ovf}, 32'd0);
        end
        wen = 1'b0;
        ren = 1'b0;
        for (int i = 3; i < 8; i++) rd_expect(16'h0020 + 16'(i));
        for (int k = 0; k < 3; k++) rd_expect(16'h0030 + 16'(k));
        check("b_wrap_empty", {31'h0, m_empty}, 32'd1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) wr(16'h0040 + 16'(i));
        check("b_cnt5", m_count, 32'd5);
        din = 16'h0045;
        wen = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check("arst_cnt", m_count, 32'd0);
        check("arst_empty", {31'h0, m_empty}, 32'd1);
        check("arst_ae", {31'h0, m_ae}, 32'd1);
        check("arst_af", {31'h0, m_af}, 32'd0);
        check("arst_valid", {31'h0, m_valid}, 32'd0);
        check("arst_dout", m_dout, 32'd0);
        wen = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        wr(16'hBEEF);
        check("beef_cnt", m_count, 32'd1);
`ifdef FIFO_FWFT_EN
        check("beef_fall_dout", m_dout, 32'h0000BEEF);
        check("beef_fall_valid", {31'h0, m_valid}, 32'd1);
`endif
        rd_expect(16'hBEEF);
        check("beef_empty", {31'h0, m_empty}, 32'd1);
        tick();
        check("beef_valid_idle", {31'h0, m_valid}, 32'd0);
        check("beef_cnt0", m_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
